cla_subtractor_pipe: RTL and testbench
======================================

// Module: cla_subtractor_pipe
// PURPOSE
//   Two-stage pipelined WIDTH-bit subtractor with borrow-in/borrow-out, built from carry-lookahead logic.
//   Computes diff = a - b - bin as a + ~b + ~bin.
//   Complements the team's combinational lookahead adder on the inverse operation.
//   Sits between operand producers and consumers in the datapath; ready/valid handshake on both sides.
// PARAMETERS
//   WIDTH  8  operand/result width; must be even (split into two WIDTH/2 halves, one per stage)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      synchronous, active-low reset
//   in_valid   in   1      operands a/b/bin valid
//   in_ready   out  1      stage 1 can accept this cycle
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow in
//   out_valid  out  1      diff/bout/ovf valid
//   out_ready  in   1      consumer accepts this cycle
//   diff       out  WIDTH  result
//   bout       out  1      borrow out (1 = unsigned a < b+bin)
//   ovf        out  1      signed overflow: (a[MSB]!=b[MSB]) && (raw diff[MSB]!=a[MSB])
// BEHAVIOUR
//   - Reset (rst_n==0 at clk edge): s1_valid=0, out_valid=0, diff=0, bout=0, ovf=0; in-flight ops dropped.
//     in_ready is 0 while rst_n==0.
//   - Stage 1 on accept (in_valid && in_ready):
//     - low half: lookahead sum of a[L] + ~b[L] + ~bin -> register d_lo and c_mid.
//     - also register a[H], ~b[H], a[MSB], b[MSB] for stage 2.
//   - Stage 2 on advance:
//     - high half: lookahead sum with carry-in c_mid.
//     - register diff = {d_hi, d_lo}, bout = ~c_out, ovf per formula above.
//   - Handshake:
//     - s2_free = ~out_valid | out_ready; s1 advances when s1_valid && s2_free.
//     - in_ready = rst_n && (~s1_valid | s2_free), combinational.
//     - out_valid clears on out_ready && ~s1 advance.
//   - Latency: exactly 2 cycles from accept to out_valid when unstalled.
//   - Throughput: 1 op/cycle; no bubbles under continuous out_ready.
//   - Stall: while out_valid && ~out_ready, diff/bout/ovf held stable. Max 2 ops buffered; order preserved.
//   - Simultaneous accept at stage 1 and drain at stage 2 in one cycle is legal and loses nothing.
//   - Wrap-around: without saturation, diff = (a - b - bin) mod 2^WIDTH.
//     Boundary example: a=0, b=0, bin=1 -> diff=all-ones, bout=1.
//   - No combinational path from a/b to outputs. in_ready depends only on state, out_ready and rst_n.
// CONFIGURATION
//   CLA_SUB_SAT_EN defined: unsigned saturation.
//     - When bout==1, diff is forced to 0; bout still reported as 1.
//     - ovf is unchanged (computed from the unsaturated result).
//   CLA_SUB_SAT_EN undefined: diff wraps modulo 2^WIDTH; no clamp logic.
// STRUCTURE
//   - Shared package arith_pkg: default width constant ARITH_W=8 and half-width derivation.
//     Same constant is used by the lookahead adder users.
//   - Sub-module cla_block (N-bit generate/propagate lookahead sum with cin/cout):
//     - instantiated twice, low half in stage 1, high half in stage 2.
//     - purely combinational.
//   - Top holds pipeline registers, valid flags, handshake and saturation.
// TESTING
//   1. a=8'h50,b=8'h20,bin=0, out_ready=1 -> 2 cycles later diff=8'h30, bout=0, ovf=0.
//   2. a=8'h00,b=8'h01,bin=0 -> diff=8'hFF, bout=1; with CLA_SUB_SAT_EN diff=8'h00, bout=1.
//   3. a=8'h10,b=8'h01,bin=1 (borrow crosses stage boundary) -> diff=8'h0E, bout=0.
//   4. a=8'h80,b=8'h01,bin=0 -> diff=8'h7F, bout=0, ovf=1. a=8'h7F,b=8'hFF -> diff=8'h80, bout=1, ovf=1.
//   5. Backpressure:
//      - stimulus: 4 back-to-back ops, out_ready low for 3 cycles after first out_valid.
//      - response: in_ready drops after 2 ops held; outputs stable; all 4 results in order, none lost or duplicated.
//   6. Reset mid-operation: rst_n=0 for one edge with both stages full -> next cycle out_valid=0, diff=0; no stale result emerges afterwards.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic constants for the lookahead adder/subtractor family.
// ARITH_W : default datapath width shared with the lookahead adder users.
// half_w  : width of one pipeline half when an operand is split in two.
package arith_pkg;

  localparam int unsigned ARITH_W = 8;

  // Width of one half of an operand split across two pipeline stages.
  function automatic int unsigned half_w(input int unsigned w);
    return w / 2;
  endfunction

endpackage

// File: rtl/cla_subtractor_pipe_if.sv
// Ready/valid operand and result bus for cla_subtractor_pipe.
// Operand side : in_valid, in_ready, a, b, bin
// Result side  : out_valid, out_ready, diff, bout, ovf
// master = producer/consumer side, slave = the subtractor.
interface cla_subtractor_pipe_if
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );

endinterface

// File: rtl/cla_subtractor_pipe_cla_block.sv
// N-bit generate/propagate carry-lookahead sum, purely combinational.
// i_x, i_y  : addends
// i_cin     : carry in
// o_sum_c   : i_x + i_y + i_cin (low N bits)
// o_cout_c  : carry out
module cla_block #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] i_x,
  input  logic [N-1:0] i_y,
  input  logic         i_cin,
  output logic [N-1:0] o_sum_c,
  output logic         o_cout_c
);

  logic [N-1:0] w_g;
  logic [N-1:0] w_p;
  logic [N:0]   w_c;
  logic         w_acc;
  logic         w_pp;

  assign w_g = i_x & i_y;
  assign w_p = i_x ^ i_y;

  // Each carry is a flat sum of products over lower generates and cin,
  // so no carry depends on another carry.
  always_comb begin
    w_c   = '0;
    w_acc = 1'b0;
    w_pp  = 1'b0;
    w_c[0] = i_cin;
    for (int i = 0; i < int'(N); i++) begin
      w_acc = w_g[i];
      w_pp  = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_acc = w_acc | (w_pp & w_g[j]);
        w_pp  = w_pp & w_p[j];
      end
      w_c[i+1] = w_acc | (w_pp & i_cin);
    end
  end

  assign o_sum_c  = w_p ^ w_c[N-1:0];
  assign o_cout_c = w_c[N];

endmodule

// File: rtl/cla_subtractor_pipe.sv
// Two-stage pipelined WIDTH-bit subtractor: diff = a - b - bin computed as
// a + ~b + ~bin with lookahead halves, low half in stage 1, high in stage 2.
// clk, rst_n : clock, synchronous active-low reset
// bus        : ready/valid operand/result interface (slave modport)
// Optional feature macro CLA_SUB_SAT_EN: unsigned saturation (diff forced
// to 0 on borrow out; bout and ovf unaffected).
module cla_subtractor_pipe
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cla_subtractor_pipe_if.slave  bus
);

  localparam int unsigned HW = half_w(WIDTH);

  // Stage 1 registers
  logic          r_s1_valid;
  logic [HW-1:0] r_d_lo;
  logic          r_c_mid;
  logic [HW-1:0] r_a_hi;
  logic [HW-1:0] r_nb_hi;
  logic          r_a_msb;
  logic          r_b_msb;

  // Stage 2 (output) registers
  logic             r_out_valid;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic          w_s2_free;
  logic          w_s1_adv;
  logic          w_in_ready;
  logic          w_accept;
  logic [HW-1:0] w_d_lo;
  logic          w_c_mid;
  logic [HW-1:0] w_d_hi;
  logic          w_c_out;
  logic [WIDTH-1:0] w_diff_raw;

  // Handshake
  assign w_s2_free  = ~r_out_valid | bus.out_ready;
  assign w_s1_adv   = r_s1_valid & w_s2_free;
  assign w_in_ready = rst_n & (~r_s1_valid | w_s2_free);
  assign w_accept   = bus.in_valid & w_in_ready;

  // Low half: a[L] + ~b[L] + ~bin
  cla_block #(.N(HW)) u_cla_lo (
    .i_x      (bus.a[HW-1:0]),
    .i_y      (~bus.b[HW-1:0]),
    .i_cin    (~bus.bin),
    .o_sum_c  (w_d_lo),
    .o_cout_c (w_c_mid)
  );

  // High half: carry from low half enters here
  cla_block #(.N(HW)) u_cla_hi (
    .i_x      (r_a_hi),
    .i_y      (r_nb_hi),
    .i_cin    (r_c_mid),
    .o_sum_c  (w_d_hi),
    .o_cout_c (w_c_out)
  );

  assign w_diff_raw = {w_d_hi, r_d_lo};

  // Stage 1 pipeline register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_d_lo     <= '0;
      r_c_mid    <= 1'b0;
      r_a_hi     <= '0;
      r_nb_hi    <= '0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_d_lo     <= w_d_lo;
      r_c_mid    <= w_c_mid;
      r_a_hi     <= bus.a[WIDTH-1:HW];
      r_nb_hi    <= ~bus.b[WIDTH-1:HW];
      r_a_msb    <= bus.a[WIDTH-1];
      r_b_msb    <= bus.b[WIDTH-1];
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2 / output register; data held while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_s1_adv) begin
      r_out_valid <= 1'b1;
`ifdef CLA_SUB_SAT_EN
      r_diff      <= w_c_out ? w_diff_raw : '0;
`else
      r_diff      <= w_diff_raw;
`endif
      r_bout      <= ~w_c_out;
      // Overflow judged on the unsaturated result
      r_ovf       <= (r_a_msb != r_b_msb) && (w_diff_raw[WIDTH-1] != r_a_msb);
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// Self-checking bench for cla_subtractor_pipe: vector table plus random
// traffic through a scoreboard queue, backpressure and mid-flight reset.
module tb_cla_subtractor_pipe;
  import arith_pkg::*;

  localparam int unsigned W = ARITH_W;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cla_subtractor_pipe_if #(.WIDTH(W)) bus ();

  cla_subtractor_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   stall_cnt = 0;
  exp_t q[$];
  bit   rand_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t sat_adj(input exp_t e);
    exp_t r = e;
`ifdef CLA_SUB_SAT_EN
    if (e.bout) r.diff = '0;
`endif
    return r;
  endfunction

  // Reference: plain wide subtraction
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] full;
    exp_t e;
    full   = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
    e.diff = full[W-1:0];
    e.bout = full[W];
    e.ovf  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    return sat_adj(e);
  endfunction

  // Caller enters just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input exp_t e);
    int waits = 0;
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.a   = a;
    bus.b   = b;
    bus.bin = bin;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(e);
        done = 1'b1;
      end else begin
        waits++;
        stall_cnt++;
        if (waits > 200) begin
          $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
          $fatal(1, "send timeout");
        end
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(q.size()), 32'd0);
  endtask

  // Output monitor: scoreboard pop on transfer, stability while stalled
  logic held_v = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    exp_t cur;
    exp_t e;
    cur.diff = bus.diff;
    cur.bout = bus.bout;
    cur.ovf  = bus.ovf;
    if (rst_n && held_v)
      check("stall_stable", 32'(cur), 32'(held));
    held_v = rst_n && bus.out_valid && !bus.out_ready;
    held   = cur;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got diff=%0h with empty scoreboard", cur.diff);
      end else begin
        e = q.pop_front();
        check("result", 32'(cur), 32'(e));
      end
    end
  end

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[8] = '{8'h0F, 8'h0F, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Latency: single op into an empty pipe
    send(vecs[0].a, vecs[0].b, vecs[0].bin, sat_adj('{vecs[0].d, vecs[0].bo, vecs[0].ov}));
    @(negedge clk);
    check("lat_cycle1_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 32'(bus.out_valid), 32'd1);
    drain("drain_latency");
    @(posedge clk);
    #1;

    // Vector table back-to-back; no stalls expected under continuous out_ready
    stall_cnt = 0;
    for (int i = 0; i < 10; i++)
      send(vecs[i].a, vecs[i].b, vecs[i].bin, sat_adj('{vecs[i].d, vecs[i].bo, vecs[i].ov}));
    check("table_no_bubble", 32'(stall_cnt), 32'd0);
    drain("drain_table");
    @(posedge clk);
    #1;

    // Backpressure: 4 ops, consumer stalls 3 cycles after first out_valid
    stall_cnt = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        send(8'h33, 8'h11, 1'b0, model(8'h33, 8'h11, 1'b0));
        send(8'h05, 8'h09, 1'b1, model(8'h05, 8'h09, 1'b1));
        send(8'hC0, 8'h41, 1'b0, model(8'hC0, 8'h41, 1'b0));
        send(8'h01, 8'h01, 1'b1, model(8'h01, 8'h01, 1'b1));
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("bp_first_valid", 32'(bus.out_valid), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
      end
    join
    check("bp_in_ready_drop", 32'(stall_cnt > 0), 32'd1);
    drain("drain_backpressure");
    @(posedge clk);
    #1;

    // Random traffic with random consumer stalls
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [W-1:0] ra;
          logic [W-1:0] rb;
          logic         rbin;
          ra   = W'($urandom);
          rb   = W'($urandom);
          rbin = 1'($urandom_range(0, 1));
          send(ra, rb, rbin, model(ra, rb, rbin));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #2;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    drain("drain_random");
    @(posedge clk);
    #1;

    // Reset with both stages full
    bus.out_ready = 1'b0;
    send(8'hAA, 8'h55, 1'b0, model(8'hAA, 8'h55, 1'b0));
    send(8'h12, 8'h34, 1'b1, model(8'h12, 8'h34, 1'b1));
    q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_diff", 32'(bus.diff), 32'd0);
    check("midrst_flags", 32'({bus.bout, bus.ovf}), 32'd0);
    bus.out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("midrst_no_stale", 32'(bus.out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
